// File: rtl/x_top_uart_rx_ctrl_if.sv
// Bus and receive-side signal bundle for the UART receive controller.
// The slave modport is the controller's view; master is the bus/receiver side.
interface x_top_uart_rx_ctrl_if;
    logic       i_rx_valid;
    logic [7:0] i_rx_data;
    logic       i_sel;
    logic       i_wr;
    logic [1:0] i_addr;
    logic [7:0] i_wdata;
    logic [7:0] o_rdata;
    logic       o_ack;
    logic       o_irq;

    // Access handshake: i_sel is a one-cycle request (no back-pressure);
    // o_ack pulses exactly one cycle later with o_rdata valid in that cycle.
    modport slave (
        input  i_rx_valid, i_rx_data, i_sel, i_wr, i_addr, i_wdata,
        output o_rdata, o_ack, o_irq
    );

    modport master (
        output i_rx_valid, i_rx_data, i_sel, i_wr, i_addr, i_wdata,
        input  o_rdata, o_ack, o_irq
    );
endinterface

// File: rtl/x_top_uart_rx_ctrl.sv
// UART receive controller: byte FIFO for received data, a small register
// map (DATA/STATUS/CTRL/CLEAR) and a threshold/overflow level interrupt.
module x_top_uart_rx_ctrl #(
    parameter int p_depth = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    x_top_uart_rx_ctrl_if.slave   bus
);
    localparam int pw = $clog2(p_depth);
    localparam int cw = $clog2(p_depth + 1);
    localparam logic [cw-1:0] full_cnt = cw'(p_depth);
    localparam logic [pw-1:0] last_ptr = pw'(p_depth - 1);

    logic [7:0]    mem [p_depth];
    logic [pw-1:0] rd_ptr, wr_ptr;
    logic [cw-1:0] count;
    logic          ovf, rx_en, irq_en;
    logic [3:0]    thresh;
    logic [7:0]    rdata;
    logic          ack;

    logic       rd_acc, wr_acc, is_empty, is_full;
    logic       pop, push, flush, ovf_clr, ovf_set, rx_take, irq;
    logic [4:0] eff_thresh;
    logic [7:0] status, ctrl_val, rd_mux;

    function automatic logic [pw-1:0] next_ptr(input logic [pw-1:0] p);
        return (p == last_ptr) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rd_acc   = bus.i_sel & ~bus.i_wr;
        wr_acc   = bus.i_sel & bus.i_wr;
        is_empty = (count == '0);
        is_full  = (count == full_cnt);
        pop      = rd_acc && (bus.i_addr == 2'd0) && !is_empty;
        flush    = wr_acc && (bus.i_addr == 2'd3) && bus.i_wdata[0];
        ovf_clr  = wr_acc && (bus.i_addr == 2'd3) && bus.i_wdata[1];
        // rx_en is the registered value, so a byte arriving with a CTRL
        // write that disables reception is still taken.
        rx_take  = bus.i_rx_valid & rx_en;
        push     = rx_take & (!is_full | pop) & !flush;
        ovf_set  = rx_take & is_full & !pop & !flush;

        if (thresh == 4'd0)
            eff_thresh = 5'd1;
        else if ({1'b0, thresh} > 5'(p_depth))
            eff_thresh = 5'(p_depth);
        else
            eff_thresh = {1'b0, thresh};

        irq      = irq_en & ((5'(count) >= eff_thresh) | ovf);
        status   = {4'(count), irq, ovf, is_full, !is_empty};
        ctrl_val = {thresh, 2'b00, irq_en, rx_en};

        rd_mux = 8'h00;
        case (bus.i_addr)
            2'd0:    rd_mux = is_empty ? 8'h00 : mem[rd_ptr];
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = ctrl_val;
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            rx_en  <= 1'b0;
            irq_en <= 1'b0;
            thresh <= 4'd0;
            rdata  <= 8'h00;
            ack    <= 1'b0;
        end else begin
            ack <= bus.i_sel;
            if (bus.i_sel)
                rdata <= bus.i_wr ? 8'h00 : rd_mux;

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= next_ptr(wr_ptr);
                if (pop)  rd_ptr <= next_ptr(rd_ptr);
                if (push && !pop)
                    count <= count + 1'b1;
                else if (pop && !push)
                    count <= count - 1'b1;
            end

            // A new overflow wins over a same-cycle clear request.
            if (ovf_set)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;

            if (wr_acc && bus.i_addr == 2'd2) begin
                rx_en  <= bus.i_wdata[0];
                irq_en <= bus.i_wdata[1];
                thresh <= bus.i_wdata[7:4];
            end
        end
    end

    // Storage is deliberately not reset; count gates all visibility.
    always_ff @(posedge i_clk) begin
        if (push && !i_rst)
            mem[wr_ptr] <= bus.i_rx_data;
    end

    assign bus.o_rdata = rdata;
    assign bus.o_ack   = ack;
    assign bus.o_irq   = irq;
endmodule

// File: doc/x_top_uart_rx_ctrl.md
X_TOP_UART_RX_CTRL -- requirements
Module: x_top_uart_rx_ctrl

Interface
REQ-001 SHALL have parameter p_depth, default 4, receive FIFO depth in bytes; legal values 2, 4 or 8.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port i_clk, input, 1, rising-edge clock for all state.
REQ-004 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_rx_valid, input, 1, one-cycle strobe marking a received, parity-checked byte.
REQ-006 SHALL have port i_rx_data, input, 8, received byte, sampled when i_rx_valid=1.
REQ-007 SHALL have port i_sel, input, 1, bus access strobe, one cycle per access.
REQ-008 SHALL have port i_wr, input, 1, 1=write, 0=read, qualified by i_sel.
REQ-009 SHALL have port i_addr, input, 2, register select.
REQ-010 SHALL have port i_wdata, input, 8, write data.
REQ-011 SHALL have port o_rdata, output, 8, registered read data.
REQ-012 SHALL have port o_ack, output, 1, access-complete strobe.
REQ-013 SHALL have port o_irq, output, 1, level interrupt.

Function
REQ-014 SHALL implement a p_depth-entry byte FIFO with read pointer, write pointer and a count of width $clog2(p_depth+1); pointers wrap from p_depth-1 to 0.
REQ-015 SHALL implement register map: 0 DATA (R), 1 STATUS (R), 2 CTRL (R/W), 3 CLEAR (W).
REQ-016 SHALL define CTRL: [0] rx_en, [1] irq_en, [7:4] thresh; bits [3:2] read 0 and ignore writes.
REQ-017 SHALL define STATUS: [0] not empty, [1] full, [2] overflow (sticky), [3] o_irq, [7:4] count.
REQ-018 SHALL push i_rx_data when i_rx_valid=1, rx_en=1 and (count<p_depth or a pop occurs the same cycle).
REQ-019 SHALL, when i_rx_valid=1 and rx_en=1 with FIFO full and no pop that cycle, drop the byte, hold the FIFO contents, and set overflow.
REQ-020 SHALL, when i_rx_valid=1 and rx_en=0, drop the byte without setting overflow.
REQ-021 SHALL, on a read of DATA with count>0, return the head byte and pop it; on a read of DATA when empty, return 0x00, no pointer change, no flag change.
REQ-022 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-023 SHALL respond to any i_sel=1 cycle with o_ack=1 and o_rdata valid on the following cycle (latency 1); o_ack SHALL be 0 otherwise.
REQ-024 SHALL drive o_rdata=0x00 for writes and for reads of address 3, and hold o_rdata at its last value when o_ack=0.
REQ-025 SHALL define a CLEAR write as follows: bit0=1 flushes the FIFO (pointers and count to 0), and bit1=1 clears overflow; both SHALL take effect the following cycle.
REQ-026 SHALL give a flush priority over a same-cycle push: the pushed byte is discarded and overflow is not set.
REQ-027 SHALL give an overflow set priority over a same-cycle overflow clear.
REQ-028 SHALL drive o_irq = irq_en & (count >= eff_thresh | overflow), where eff_thresh = 1 when thresh=0, p_depth when thresh>p_depth, and thresh otherwise; o_irq is combinational from registered state only.
REQ-029 SHALL take a CTRL write effect from the next cycle; a push coincident with a write clearing rx_en SHALL still be accepted.

Reset
REQ-030 SHALL, on i_rst=1 at a rising edge, set count, pointers, overflow, CTRL to 0, o_rdata=0x00, o_ack=0, giving o_irq=0.
REQ-031 SHALL give i_rst priority over all bus and receive activity in the same cycle.
REQ-032 SHALL leave FIFO storage contents unreset; stored bytes are unobservable after reset because count=0.

Verification
REQ-033 SHALL be verified as follows: write CTRL=0x01, push 0x11, 0x22, then read DATA twice -> rdata 0x11 then 0x22, each with o_ack one cycle after i_sel; STATUS then reads 0x00.
REQ-034 SHALL be verified as follows: with p_depth=4 and rx_en=1, push 5 bytes 0xA0..0xA4 -> STATUS=0x47; DATA reads return 0xA0..0xA3; then write CLEAR=0x02 -> STATUS=0x00.
REQ-035 SHALL be verified as follows: with FIFO full, push 0xB5 in the same cycle as a DATA read -> read returns the old head, count stays 4, overflow stays 0, and 0xB5 is read last.
REQ-036 SHALL be verified as follows: with CTRL=0x23 (irq_en, thresh=2), push one byte -> o_irq=0; push a second byte -> o_irq=1 the cycle after the push; one DATA read -> o_irq=0.
REQ-037 SHALL be verified as follows: with rx_en=0, push 0x55 -> STATUS=0x00; write CLEAR=0x01 in the same cycle as a push with rx_en=1 -> count=0.
REQ-038 SHALL be verified as follows: assert i_rst mid-operation with 3 bytes queued and a read in flight -> the next cycle shows o_ack=0, o_rdata=0x00, and STATUS=0x00.
